dijkstra_controller: RTL and testbench
======================================

Name: dijkstra_controller

Overview:
Sequencer that runs single-source Dijkstra by driving the set/get side of the distance priority queue. It owns the visited vector and the adjacency-memory read port. It repeatedly takes the queue's min unvisited node and relaxes all of that node's out-edges by read-compare-write into the queue. Final distances are left in the queue for readout after done.

Parameters:
MAX_NODES, `DEFAULT_MAX_NODES (8), number of graph nodes.
INDEX_WIDTH, `DEFAULT_INDEX_WIDTH (3), node index width; 2**INDEX_WIDTH >= MAX_NODES.
VALUE_WIDTH, `DEFAULT_VALUE_WIDTH (8), distance/weight width; `INFINITY = all ones.

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  synchronous, active-high
start  in  1  begin run; sampled only in IDLE
source  in  INDEX_WIDTH  source node, latched with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
edge_addr  out  2*INDEX_WIDTH  {row=current node, col=neighbour j}
edge_weight  in  VALUE_WIDTH  weight row->col, valid the cycle after edge_addr; `INFINITY = no edge
pq_reset  out  1  queue reset: all dist `INFINITY, dist[pq_index]=0
pq_set_en  out  1  write pq_write_value to dist[pq_index] at clock edge
pq_index  out  INDEX_WIDTH  queue access index
pq_write_value  out  VALUE_WIDTH  value written when pq_set_en
pq_read_value  in  VALUE_WIDTH  dist[pq_index], combinational
pq_min_index  in  INDEX_WIDTH  min-distance unvisited node
pq_min_value  in  VALUE_WIDTH  dist[pq_min_index]
visited_vector  out  MAX_NODES  bit set = node finalized (set != `UNVISITED)

Behaviour:
- Reset: state IDLE; busy, done, pq_reset, pq_set_en = 0; visited_vector = all `UNVISITED; pq_index, pq_write_value, edge_addr = 0. Reset mid-run aborts immediately; queue contents undefined until the next INIT.
- IDLE: start=1 latches source, goes to INIT. start in any other state is ignored.
- INIT (1 cycle): pq_reset=1, pq_index=latched source; visited cleared. Next: SELECT.
- SELECT (1 cycle): if visited_vector all set, or visited[pq_min_index] set, or pq_min_value==`INFINITY -> DONE. Else cur<=pq_min_index, cur_dist<=pq_min_value, visited[cur]<=1, j<=0 -> FETCH.
- FETCH (1 cycle): edge_addr={cur,j}. Next: RELAX.
- RELAX (1 cycle): pq_index=j. sum = cur_dist + edge_weight in VALUE_WIDTH+1 bits. pq_set_en=1 and pq_write_value=sum[VALUE_WIDTH-1:0] iff all hold:
  - visited[j] clear
  - edge_weight != `INFINITY
  - sum < `INFINITY (no overflow; saturating, never wraps)
  - sum < pq_read_value (strict; ties keep the old value)
  Then if j==MAX_NODES-1 -> SELECT, else j<=j+1 -> FETCH.
- DONE (1 cycle): done=1, busy=1. Next: IDLE.
- pq_set_en and pq_reset are never high outside RELAX and INIT respectively, and never together.
- Latency, N=MAX_NODES, all nodes reachable: start edge, then INIT + N*(1+2N) + final SELECT. done is high in the cycle after that. N=4: done in cycle 39 after the start edge.
- Unreachable nodes end the run early via the `INFINITY check; their dist stays `INFINITY.
- Self-loops and edges to visited nodes are never written.

Decomposition:
- Shared constants header (existing): `INFINITY, `UNVISITED, `DEFAULT_MAX_NODES/INDEX_WIDTH/VALUE_WIDTH.
- State encoding is local localparams.
- One natural sub-module: dijkstra_relax. It is combinational: widened saturating add plus the four-way write condition, and outputs write_en and write_value.

Test Plan:
- 4 nodes, edges 0->1=4, 0->2=1, 2->1=2, 1->3=5, source 0 -> final dist {0,3,1,8}; done at cycle 39; visited=4'b1111.
- Remove 1->3, same stimulus -> dist3=255 (`INFINITY); done pulses before cycle 39 via early exit; visited[3]=0.
- Source 2, edges 2->0=200, 0->1=100 -> sum 300 saturates, so there is no write; dist {200,255,0,255}.
- Tie case: 0->1=3, 0->2=1, 2->1=2 -> no write at the tie (pq_set_en low for j=1 in the second relax); dist1=3.
- start pulsed again at cycle 10 while busy -> ignored; results match the first scenario.
- reset asserted at cycle 15 -> next cycle busy=0, pq_set_en=0, visited=0. A fresh start then gives the first scenario's results.

Source files
------------

// File: rtl/dijkstra_controller_pkg.sv
// Shared constants and default sizing for the Dijkstra sequencer and its relax datapath.
// Distances saturate at all-ones, which doubles as the "no edge / unreached" marker.
package dijkstra_controller_pkg;

  localparam int DEFAULT_MAX_NODES   = 8;
  localparam int DEFAULT_INDEX_WIDTH = 3;
  localparam int DEFAULT_VALUE_WIDTH = 8;

  localparam logic UNVISITED = 1'b0;
  localparam logic VISITED   = 1'b1;

endpackage

// File: rtl/dijkstra_controller_if.sv
// Bundle of the run-control, adjacency-memory and priority-queue signals of the controller.
// The master modport is the controller side; the slave modport is the queue/memory/host side.
interface dijkstra_controller_if #(
  parameter int MAX_NODES   = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int VALUE_WIDTH = 8
) ();

  logic                     start;
  logic [INDEX_WIDTH-1:0]   source;
  logic                     busy;
  logic                     done;
  logic [2*INDEX_WIDTH-1:0] edge_addr;
  logic [VALUE_WIDTH-1:0]   edge_weight;
  logic                     pq_reset;
  logic                     pq_set_en;
  logic [INDEX_WIDTH-1:0]   pq_index;
  logic [VALUE_WIDTH-1:0]   pq_write_value;
  logic [VALUE_WIDTH-1:0]   pq_read_value;
  logic [INDEX_WIDTH-1:0]   pq_min_index;
  logic [VALUE_WIDTH-1:0]   pq_min_value;
  logic [MAX_NODES-1:0]     visited_vector;

  modport master (
    input  start, source, edge_weight, pq_read_value, pq_min_index, pq_min_value,
    output busy, done, edge_addr, pq_reset, pq_set_en, pq_index, pq_write_value,
           visited_vector
  );

  modport slave (
    output start, source, edge_weight, pq_read_value, pq_min_index, pq_min_value,
    input  busy, done, edge_addr, pq_reset, pq_set_en, pq_index, pq_write_value,
           visited_vector
  );

endinterface

// File: rtl/dijkstra_relax.sv
// Combinational edge relaxation: widened add so an overflowing path saturates instead of wrapping,
// and a write only when the neighbour is open, the edge exists and the new path is strictly shorter.
module dijkstra_relax
  import dijkstra_controller_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic [VALUE_WIDTH-1:0] cur_dist,
  input  logic [VALUE_WIDTH-1:0] edge_weight,
  input  logic [VALUE_WIDTH-1:0] read_value,
  input  logic                   visited_j,
  output logic                   write_en,
  output logic [VALUE_WIDTH-1:0] write_value
);

  localparam logic [VALUE_WIDTH-1:0] INF = '1;

  logic [VALUE_WIDTH:0] sum;

  always_comb begin
    sum         = {1'b0, cur_dist} + {1'b0, edge_weight};
    write_value = sum[VALUE_WIDTH-1:0];
    write_en    = (visited_j == UNVISITED) &&
                  (edge_weight != INF) &&
                  (sum < {1'b0, INF}) &&
                  (sum < {1'b0, read_value});
  end

endmodule

// File: rtl/dijkstra_controller.sv
// Single-source Dijkstra sequencer: select min unvisited node, then fetch/relax each of its out-edges.
// Final distances stay in the external priority queue; done pulses for one cycle at the end of a run.
module dijkstra_controller
  import dijkstra_controller_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  dijkstra_controller_if.master bus
);

  localparam logic [VALUE_WIDTH-1:0] INF      = '1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(MAX_NODES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SELECT = 3'd2,
    ST_FETCH  = 3'd3,
    ST_RELAX  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e                 state_q,    state_d;
  logic [INDEX_WIDTH-1:0] source_q,   source_d;
  logic [INDEX_WIDTH-1:0] cur_q,      cur_d;
  logic [VALUE_WIDTH-1:0] cur_dist_q, cur_dist_d;
  logic [INDEX_WIDTH-1:0] j_q,        j_d;
  logic [MAX_NODES-1:0]   visited_q,  visited_d;

  logic                   relax_en;
  logic [VALUE_WIDTH-1:0] relax_value;

  dijkstra_relax #(
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_relax (
    .cur_dist    (cur_dist_q),
    .edge_weight (bus.edge_weight),
    .read_value  (bus.pq_read_value),
    .visited_j   (visited_q[j_q]),
    .write_en    (relax_en),
    .write_value (relax_value)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      source_q   <= '0;
      cur_q      <= '0;
      cur_dist_q <= '0;
      j_q        <= '0;
      visited_q  <= {MAX_NODES{UNVISITED}};
    end else begin
      state_q    <= state_d;
      source_q   <= source_d;
      cur_q      <= cur_d;
      cur_dist_q <= cur_dist_d;
      j_q        <= j_d;
      visited_q  <= visited_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    source_d           = source_q;
    cur_d              = cur_q;
    cur_dist_d         = cur_dist_q;
    j_d                = j_q;
    visited_d          = visited_q;

    bus.busy           = (state_q != ST_IDLE);
    bus.done           = 1'b0;
    bus.pq_reset       = 1'b0;
    bus.pq_set_en      = 1'b0;
    bus.pq_index       = '0;
    bus.pq_write_value = '0;
    bus.edge_addr      = '0;
    bus.visited_vector = visited_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          source_d = bus.source;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        bus.pq_reset = 1'b1;
        bus.pq_index = source_q;
        visited_d    = {MAX_NODES{UNVISITED}};
        state_d      = ST_SELECT;
      end
      ST_SELECT: begin
        // The queue's min ignores visited nodes, so a visited or infinite min means nothing reachable is left.
        if ((&visited_q) || (visited_q[bus.pq_min_index] == VISITED) ||
            (bus.pq_min_value == INF)) begin
          state_d = ST_DONE;
        end else begin
          cur_d                        = bus.pq_min_index;
          cur_dist_d                   = bus.pq_min_value;
          visited_d[bus.pq_min_index]  = VISITED;
          j_d                          = '0;
          state_d                      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        bus.edge_addr = {cur_q, j_q};
        state_d       = ST_RELAX;
      end
      ST_RELAX: begin
        bus.pq_index       = j_q;
        bus.pq_set_en      = relax_en;
        bus.pq_write_value = relax_en ? relax_value : '0;
        if (j_q == LAST_IDX) begin
          state_d = ST_SELECT;
        end else begin
          j_d     = j_q + INDEX_WIDTH'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dijkstra_controller.sv
// Bench for dijkstra_controller: behavioural queue and adjacency memory around the DUT,
// directed scenarios plus random graphs compared against a plain Dijkstra reference.
module tb_dijkstra_controller;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int VW = 8;
  localparam logic [VW-1:0] INF = 8'hFF;
  localparam int RUN_CYCLES_PER_NODE = 1 + 2 * N;

  logic clock;
  logic reset;

  dijkstra_controller_if #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) bus ();

  dijkstra_controller #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [VW-1:0] adj    [N][N];
  logic [VW-1:0] dist_m [N];

  int total;
  int bad;
  int wr_cnt;
  int viol;
  int done_cnt;

  logic [VW-1:0] ref_dist [N];
  logic [N-1:0]  ref_vis;
  int            ref_writes;
  int            ref_nvis;

  // Queue model: synchronous reset/set, combinational read and min-over-unvisited (lowest index on ties).
  always @(posedge clock) begin
    if (bus.pq_reset) begin
      for (int i = 0; i < N; i++) dist_m[i] <= (i == int'(bus.pq_index)) ? '0 : INF;
    end else if (bus.pq_set_en) begin
      dist_m[bus.pq_index] <= bus.pq_write_value;
    end
    bus.edge_weight <= adj[bus.edge_addr[2*IW-1:IW]][bus.edge_addr[IW-1:0]];
  end

  always_comb begin
    logic          found;
    logic [IW-1:0] bi;
    logic [VW-1:0] bv;
    found = 1'b0;
    bi    = '0;
    bv    = INF;
    for (int i = 0; i < N; i++) begin
      if (!bus.visited_vector[i] && (!found || dist_m[i] < bv)) begin
        found = 1'b1;
        bi    = IW'(i);
        bv    = dist_m[i];
      end
    end
    bus.pq_min_index  = bi;
    bus.pq_min_value  = found ? bv : dist_m[0];
    bus.pq_read_value = dist_m[bus.pq_index];
  end

  always @(negedge clock) begin
    if (bus.pq_set_en) begin
      wr_cnt++;
      if (bus.pq_write_value >= dist_m[bus.pq_index] || bus.visited_vector[bus.pq_index]) viol++;
    end
    if (bus.pq_set_en && bus.pq_reset) viol++;
    if (bus.done) done_cnt++;
  end

  task automatic clear_graph();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) adj[i][j] = INF;
  endtask

  // Textbook Dijkstra over adj, with saturation and strict-improvement writes.
  task automatic ref_run(input int src);
    int cur, s;
    ref_writes = 0;
    ref_nvis   = 0;
    ref_vis    = '0;
    for (int i = 0; i < N; i++) ref_dist[i] = INF;
    ref_dist[src] = 0;
    while (ref_nvis < N) begin
      cur = -1;
      for (int i = 0; i < N; i++)
        if (!ref_vis[i] && ref_dist[i] != INF && (cur < 0 || ref_dist[i] < ref_dist[cur])) cur = i;
      if (cur < 0) break;
      ref_vis[cur] = 1'b1;
      ref_nvis++;
      for (int j = 0; j < N; j++) begin
        s = int'(ref_dist[cur]) + int'(adj[cur][j]);
        if (!ref_vis[j] && adj[cur][j] != INF && s < int'(INF) && s < int'(ref_dist[j])) begin
          ref_dist[j] = VW'(s);
          ref_writes++;
        end
      end
    end
  endtask

  task automatic start_run(input int src);
    wr_cnt   = 0;
    viol     = 0;
    done_cnt = 0;
    bus.source = IW'(src);
    bus.start  = 1'b1;
    @(posedge clock); #1;
    bus.start  = 1'b0;
    bus.source = '0;
  endtask

  // Returns the cycle (1 = INIT) in which done is seen, or -1 if the budget runs out.
  task automatic wait_done(input int ghost_at, output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      bus.start  = (cyc == ghost_at);
      bus.source = (cyc == ghost_at) ? IW'(3) : '0;
      @(posedge clock); #1;
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) cyc = -1;
    @(posedge clock); #1;
  endtask

  task automatic build_basic();
    clear_graph();
    adj[0][1] = 8'd4;
    adj[0][2] = 8'd1;
    adj[2][1] = 8'd2;
    adj[1][3] = 8'd5;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.source = '0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if ({bus.pq_reset, bus.pq_set_en} !== 2'b00) begin bad++; $display("FAIL reset_pq_ctl got=%b want=00", {bus.pq_reset, bus.pq_set_en}); end
    total++; if (bus.visited_vector !== 4'b0000) begin bad++; $display("FAIL reset_visited got=%b want=0000", bus.visited_vector); end
    total++; if ({bus.pq_index, bus.pq_write_value, bus.edge_addr} !== 14'd0) begin bad++; $display("FAIL reset_busses got=%h want=0", {bus.pq_index, bus.pq_write_value, bus.edge_addr}); end
    reset = 1'b0;
    @(posedge clock); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_no_start busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_basic();
    int cyc;
    logic [VW-1:0] exp_d [N];
    exp_d = '{8'd0, 8'd3, 8'd1, 8'd8};
    build_basic();
    ref_run(0);
    start_run(0);
    total++; if (bus.pq_reset !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL basic_init got=%b%b want=11", bus.pq_reset, bus.busy); end
    wait_done(0, cyc);
    total++; if (cyc != 39) begin bad++; $display("FAIL basic_done_cycle got=%0d want=39", cyc); end
    for (int i = 0; i < N; i++) begin
      total++; if (dist_m[i] !== exp_d[i]) begin bad++; $display("FAIL basic_dist[%0d] got=%0d want=%0d", i, dist_m[i], exp_d[i]); end
    end
    total++; if (bus.visited_vector !== 4'b1111) begin bad++; $display("FAIL basic_visited got=%b want=1111", bus.visited_vector); end
    total++; if (wr_cnt != ref_writes || viol != 0) begin bad++; $display("FAIL basic_writes got=%0d/%0d want=%0d/0", wr_cnt, viol, ref_writes); end
    total++; if (done_cnt != 1 || bus.busy !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0d busy=%b want=1 busy=0", done_cnt, bus.busy); end
  endtask

  task automatic test_unreachable();
    int cyc;
    build_basic();
    adj[1][3] = INF;
    start_run(0);
    wait_done(0, cyc);
    total++; if (cyc != 3 * RUN_CYCLES_PER_NODE + 3) begin bad++; $display("FAIL unreach_done_cycle got=%0d want=%0d", cyc, 3 * RUN_CYCLES_PER_NODE + 3); end
    total++; if (dist_m[3] !== INF) begin bad++; $display("FAIL unreach_dist3 got=%0d want=255", dist_m[3]); end
    total++; if (bus.visited_vector !== 4'b0111) begin bad++; $display("FAIL unreach_visited got=%b want=0111", bus.visited_vector); end
  endtask

  task automatic test_saturate();
    int cyc;
    logic [VW-1:0] exp_d [N];
    exp_d = '{8'd200, 8'd255, 8'd0, 8'd255};
    clear_graph();
    adj[2][0] = 8'd200;
    adj[0][1] = 8'd100;
    start_run(2);
    wait_done(0, cyc);
    for (int i = 0; i < N; i++) begin
      total++; if (dist_m[i] !== exp_d[i]) begin bad++; $display("FAIL sat_dist[%0d] got=%0d want=%0d", i, dist_m[i], exp_d[i]); end
    end
    total++; if (wr_cnt != 1 || cyc != 2 * RUN_CYCLES_PER_NODE + 3) begin bad++; $display("FAIL sat_writes_cycle got=%0d/%0d want=1/%0d", wr_cnt, cyc, 2 * RUN_CYCLES_PER_NODE + 3); end
  endtask

  task automatic test_tie();
    int cyc;
    clear_graph();
    adj[0][1] = 8'd3;
    adj[0][2] = 8'd1;
    adj[2][1] = 8'd2;
    start_run(0);
    wait_done(0, cyc);
    total++; if (dist_m[1] !== 8'd3) begin bad++; $display("FAIL tie_dist1 got=%0d want=3", dist_m[1]); end
    total++; if (wr_cnt != 2 || viol != 0) begin bad++; $display("FAIL tie_writes got=%0d/%0d want=2/0", wr_cnt, viol); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    logic [VW-1:0] exp_d [N];
    exp_d = '{8'd0, 8'd3, 8'd1, 8'd8};
    build_basic();
    start_run(0);
    wait_done(10, cyc);
    total++; if (cyc != 39) begin bad++; $display("FAIL ghost_done_cycle got=%0d want=39", cyc); end
    for (int i = 0; i < N; i++) begin
      total++; if (dist_m[i] !== exp_d[i]) begin bad++; $display("FAIL ghost_dist[%0d] got=%0d want=%0d", i, dist_m[i], exp_d[i]); end
    end
  endtask

  task automatic test_midrun_reset();
    int cyc;
    logic [VW-1:0] exp_d [N];
    exp_d = '{8'd0, 8'd3, 8'd1, 8'd8};
    build_basic();
    start_run(0);
    repeat (14) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    total++; if (bus.busy !== 1'b0 || bus.pq_set_en !== 1'b0) begin bad++; $display("FAIL midreset_ctl got=%b%b want=00", bus.busy, bus.pq_set_en); end
    total++; if (bus.visited_vector !== 4'b0000) begin bad++; $display("FAIL midreset_visited got=%b want=0000", bus.visited_vector); end
    reset = 1'b0;
    @(posedge clock); #1;
    start_run(0);
    wait_done(0, cyc);
    total++; if (cyc != 39) begin bad++; $display("FAIL midreset_rerun_cycle got=%0d want=39", cyc); end
    for (int i = 0; i < N; i++) begin
      total++; if (dist_m[i] !== exp_d[i]) begin bad++; $display("FAIL midreset_dist[%0d] got=%0d want=%0d", i, dist_m[i], exp_d[i]); end
    end
  endtask

  task automatic test_random();
    int cyc, src;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          adj[i][j] = ($urandom_range(0, 2) == 0) ? INF : VW'($urandom_range(1, 140));
      src = int'($urandom_range(0, N - 1));
      ref_run(src);
      start_run(src);
      wait_done(0, cyc);
      for (int i = 0; i < N; i++) begin
        total++; if (dist_m[i] !== ref_dist[i]) begin bad++; $display("FAIL rand%0d_dist[%0d] got=%0d want=%0d", it, i, dist_m[i], ref_dist[i]); end
      end
      total++; if (bus.visited_vector !== ref_vis) begin bad++; $display("FAIL rand%0d_visited got=%b want=%b", it, bus.visited_vector, ref_vis); end
      total++; if (cyc != ref_nvis * RUN_CYCLES_PER_NODE + 3) begin bad++; $display("FAIL rand%0d_done_cycle got=%0d want=%0d", it, cyc, ref_nvis * RUN_CYCLES_PER_NODE + 3); end
      total++; if (wr_cnt != ref_writes || viol != 0) begin bad++; $display("FAIL rand%0d_writes got=%0d/%0d want=%0d/0", it, wr_cnt, viol, ref_writes); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start  = 1'b0;
    bus.source = '0;
    clear_graph();
    test_reset();
    test_basic();
    test_unreachable();
    test_saturate();
    test_tie();
    test_start_ignored();
    test_midrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
